// File: rtl/uart_rx_deser_if.sv
// Byte-side and line-side signals of the UART receiver feeding the CNN input buffer.
// master = the receiver, slave = the host-side top level that consumes bytes.
interface uart_rx_deser_if;
  logic       RX;
  logic       clr_rx_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  RX,
    input  clr_rx_rdy,
    output rx_data,
    output rx_rdy,
    output frame_err,
    output overrun
  );

  modport slave (
    output RX,
    output clr_rx_rdy,
    input  rx_data,
    input  rx_rdy,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronizes RX, samples mid-bit, and presents each byte with rx_rdy.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_deser #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_deser_if.master bus
);

  localparam int unsigned   CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_prev       <= 1'b1;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      bus.rx_data   <= '0;
      bus.rx_rdy    <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      rx_meta       <= bus.RX;
      rx_s          <= rx_meta;
      rx_prev       <= rx_s;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      baud_cnt      <= baud_cnt + 1'b1;
      // A completing frame in STOP overrides this clear, so set wins over clear.
      if (bus.clr_rx_rdy) bus.rx_rdy <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (rx_prev && !rx_s) state <= START;
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (rx_s) begin
              bus.rx_data <= shift;
              bus.rx_rdy  <= 1'b1;
              bus.overrun <= bus.rx_rdy && !bus.clr_rx_rdy;
            end else begin
              bus.frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomized scoreboard bench for uart_rx_deser: stimulus pushes expected completion
// events (cycle, kind, data); a negedge monitor pops and compares them.
module tb_uart_rx_deser;

  localparam int BAUD = 16;
  localparam int HALF = 8;

  localparam int K_RDY  = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
    logic       rdy;
    logic       tied;
  } exp_t;

  logic clk;
  logic rst_n;
  logic tie_clr;
  int   cyc;
  int   n_checks;
  int   n_pass;

  exp_t       exp_q[$];
  logic [7:0] model_data;
  logic       model_rdy;

  uart_rx_deser_if bus ();

  assign bus.clr_rx_rdy = tie_clr ? bus.rx_rdy : 1'b0;

  uart_rx_deser #(.BAUD_DIV(BAUD), .HALF_DIV(HALF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.RX = 1'b1;
    hold(n);
  endtask

  // Reference: a frame starting at cycle c completes after 2 sync cycles, half a bit
  // to the start mid-point, nine more bit times to the stop mid-point, and one output cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    exp_t e;
    e.cyc  = cyc + 2 + HALF + 9 * BAUD + 1;
    e.tied = tie_clr;
    if (stop_ok) begin
      e.kind     = (model_rdy && !tie_clr) ? K_OVR : K_RDY;
      e.data     = d;
      e.rdy      = 1'b1;
      model_data = d;
      model_rdy  = !tie_clr;
    end else begin
      e.kind = K_FERR;
      e.data = model_data;
      e.rdy  = model_rdy;
    end
    exp_q.push_back(e);
    bus.RX = 1'b0;
    hold(BAUD);
    for (int i = 0; i < 8; i++) begin
      bus.RX = d[i];
      hold(BAUD);
    end
    bus.RX = stop_ok;
    hold(BAUD);
  endtask

  // Monitor: every output event must match the head of the expected queue.
  initial begin
    exp_t e;
    logic rdy_q;
    int   wpend;
    int   kind_act;
    exp_t last;
    rdy_q = 1'b0;
    wpend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rdy_q = 1'b0;
        wpend = 0;
      end else begin
        if (wpend != 0) begin
          if (last.kind == K_RDY)  check("rdy_after_pulse", int'(bus.rx_rdy), int'(!last.tied));
          if (last.kind == K_FERR) check("ferr_width", int'(bus.frame_err), 0);
          if (last.kind == K_OVR) begin
            check("ovr_width", int'(bus.overrun), 0);
            check("rdy_held_after_ovr", int'(bus.rx_rdy), 1);
          end
          wpend = 0;
        end
        if ((bus.rx_rdy && !rdy_q) || bus.frame_err || bus.overrun) begin
          kind_act = bus.frame_err ? K_FERR : (bus.overrun ? K_OVR : K_RDY);
          if (exp_q.size() == 0) begin
            check("unexpected_event", kind_act + 16, -1);
          end else begin
            e = exp_q.pop_front();
            check("event_cycle", cyc, e.cyc);
            check("event_kind", kind_act, e.kind);
            check("rx_data", int'(bus.rx_data), int'(e.data));
            check("rx_rdy_at_event", int'(bus.rx_rdy), int'(e.rdy));
            last  = e;
            wpend = 1;
          end
        end
        rdy_q = bus.rx_rdy;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         sel;
    int         gl;
    logic       line_low;
    n_checks   = 0;
    n_pass     = 0;
    model_data = 8'h00;
    model_rdy  = 1'b0;
    tie_clr    = 1'b1;
    bus.RX     = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", int'(bus.rx_data), 0);
    check("reset_rx_rdy", int'(bus.rx_rdy), 0);
    check("reset_frame_err", int'(bus.frame_err), 0);
    check("reset_overrun", int'(bus.overrun), 0);
    rst_n = 1'b1;
    idle(10);

    send_frame(8'hA5, 1'b1);
    idle(20);

    // Short low pulse: rejected at the start mid-point.
    bus.RX = 1'b0;
    hold(3);
    idle(30);
    send_frame(8'h3C, 1'b1);
    idle(10);

    send_frame(8'h5A, 1'b1);
    idle(5);
    send_frame(8'h3C, 1'b0);
    // Break: line stays low for 40 bit times.
    hold(40 * BAUD);
    idle(30);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);

    tie_clr = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(7);
    send_frame(8'h22, 1'b1);
    idle(3);
    tie_clr   = 1'b1;
    model_rdy = 1'b0;
    idle(10);

    line_low = 1'b0;
    for (int n = 0; n < 14; n++) begin
      idle(line_low ? 2 + $urandom_range(0, 12) : $urandom_range(0, 12));
      sel = $urandom_range(0, 9);
      d   = 8'($urandom);
      if (sel == 0) begin
        if (!line_low) idle(1);
        gl = $urandom_range(1, 6);
        bus.RX = 1'b0;
        hold(gl);
        idle(20);
        line_low = 1'b0;
      end else if (sel <= 2) begin
        send_frame(d, 1'b0);
        line_low = 1'b1;
      end else begin
        send_frame(d, 1'b1);
        line_low = 1'b0;
      end
    end
    idle(20);

    // Reset in the middle of data bit 4 discards the partial frame.
    send_frame(8'hC3, 1'b1);
    idle(10);
    d      = 8'h77;
    bus.RX = 1'b0;
    hold(BAUD);
    for (int i = 0; i < 4; i++) begin
      bus.RX = d[i];
      hold(BAUD);
    end
    bus.RX = d[4];
    hold(BAUD / 2);
    rst_n = 1'b0;
    #1;
    check("midreset_rx_data", int'(bus.rx_data), 0);
    check("midreset_rx_rdy", int'(bus.rx_rdy), 0);
    check("midreset_frame_err", int'(bus.frame_err), 0);
    check("midreset_overrun", int'(bus.overrun), 0);
    model_data = 8'h00;
    model_rdy  = 1'b0;
    bus.RX     = 1'b1;
    hold(3);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1);
    idle(200);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
